// File: rtl/pl_deframer_if.sv
// pl_deframer_if: symbol-stream bundle between a PL symbol source and the deframer.
//   Source side : fs_en, sym_vld, sof, sym_re_in/sym_im_in, xfec_slots, pilot_en
//   Sink side   : pl_header_vld, pl_pilot_vld, xfec_frame_vld,
//                 symbol_re_out/symbol_im_out, frame_done, sof_err, cfg_err
//   master = symbol source / result consumer, slave = deframer.
interface pl_deframer_if;

  localparam int unsigned SYM_W  = 16;
  localparam int unsigned SLOT_W = 9;

  // symbol source -> deframer
  logic                     fs_en;
  logic                     sym_vld;
  logic                     sof;
  logic signed [SYM_W-1:0]  sym_re_in;
  logic signed [SYM_W-1:0]  sym_im_in;
  logic [SLOT_W-1:0]        xfec_slots;
  logic                     pilot_en;

  // deframer -> consumer
  logic                     pl_header_vld;
  logic                     pl_pilot_vld;
  logic                     xfec_frame_vld;
  logic signed [SYM_W-1:0]  symbol_re_out;
  logic signed [SYM_W-1:0]  symbol_im_out;
  logic                     frame_done;
  logic                     sof_err;
  logic                     cfg_err;

  modport master (
    output fs_en, sym_vld, sof, sym_re_in, sym_im_in, xfec_slots, pilot_en,
    input  pl_header_vld, pl_pilot_vld, xfec_frame_vld,
           symbol_re_out, symbol_im_out, frame_done, sof_err, cfg_err
  );

  modport slave (
    input  fs_en, sym_vld, sof, sym_re_in, sym_im_in, xfec_slots, pilot_en,
    output pl_header_vld, pl_pilot_vld, xfec_frame_vld,
           symbol_re_out, symbol_im_out, frame_done, sof_err, cfg_err
  );

endinterface

// File: rtl/pl_deframer.sv
// pl_deframer: classifies a PL frame symbol stream into header / XFEC data /
// pilot symbols and passes the I/Q through unchanged, one sys_clk of latency.
// Ports:
//   sys_clk : clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : pl_deframer_if.slave (symbol input, class flags, I/Q output,
//             frame_done / sof_err / cfg_err pulses)
// Frame layout: 90 header symbols, then xfec_slots slots of 90 symbols, with a
// 36-symbol pilot block after every 16th slot when pilots are on (never after
// the final slot). All state advances only on fs_en=1 cycles.
module pl_deframer (
  input  logic          sys_clk,
  input  logic          rst_n,
  pl_deframer_if.slave  bus
);

  localparam int unsigned SYM_W        = 16;
  localparam int unsigned SLOT_W       = 9;
  localparam int unsigned CNT_W        = 7;
  localparam int unsigned HDR_LEN      = 90;
  localparam int unsigned SLOT_LEN     = 90;
  localparam int unsigned PILOT_LEN    = 36;
  localparam int unsigned PILOT_PERIOD = 16;
  localparam int unsigned PER_W        = $clog2(PILOT_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    PILOT  = 2'd3
  } state_t;

  // state and counters
  state_t              state_q,  state_d;
  logic [CNT_W-1:0]    sym_q,    sym_d;
  logic [SLOT_W-1:0]   slot_q,   slot_d;
  logic [SLOT_W-1:0]   slots_q,  slots_d;
  logic                pilot_q,  pilot_d;

  // registered outputs
  logic                hdr_q,    hdr_d;
  logic                pil_q,    pil_d;
  logic                xfec_q,   xfec_d;
  logic [SYM_W-1:0]    re_q,     re_d;
  logic [SYM_W-1:0]    im_q,     im_d;
  logic                done_q,   done_d;
  logic                sof_e_q,  sof_e_d;
  logic                cfg_e_q,  cfg_e_d;

  logic                last_slot_c;
  logic                pilot_due_c;
  logic                classified_c;

  // Current slot is the frame's final one; slots_q is never 0 while in DATA.
  assign last_slot_c = (slot_q == (slots_q - SLOT_W'(1)));
  // Slot index ending in 15 (mod 16) means this slot completes a group of 16.
  assign pilot_due_c = pilot_q && (slot_q[PER_W-1:0] == PER_W'(PILOT_PERIOD - 1));

  // State register plus all datapath/output registers; frozen while fs_en=0.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
      slot_q  <= '0;
      slots_q <= '0;
      pilot_q <= 1'b0;
      hdr_q   <= 1'b0;
      pil_q   <= 1'b0;
      xfec_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      done_q  <= 1'b0;
      sof_e_q <= 1'b0;
      cfg_e_q <= 1'b0;
    end else if (bus.fs_en) begin
      state_q <= state_d;
      sym_q   <= sym_d;
      slot_q  <= slot_d;
      slots_q <= slots_d;
      pilot_q <= pilot_d;
      hdr_q   <= hdr_d;
      pil_q   <= pil_d;
      xfec_q  <= xfec_d;
      re_q    <= re_d;
      im_q    <= im_d;
      done_q  <= done_d;
      sof_e_q <= sof_e_d;
      cfg_e_q <= cfg_e_d;
    end
  end

  // Next-state and output decode for one fs_en=1 cycle.
  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    slot_d       = slot_q;
    slots_d      = slots_q;
    pilot_d      = pilot_q;
    hdr_d        = 1'b0;
    pil_d        = 1'b0;
    xfec_d       = 1'b0;
    done_d       = 1'b0;
    sof_e_d      = 1'b0;
    cfg_e_d      = 1'b0;
    classified_c = 1'b0;

    if (bus.sym_vld) begin
      if (bus.sof) begin
        // sof always (re)starts a frame; this symbol is header symbol 0.
        sof_e_d      = (state_q != IDLE);
        cfg_e_d      = (bus.xfec_slots == '0);
        slots_d      = bus.xfec_slots;
        pilot_d      = bus.pilot_en;
        state_d      = HEADER;
        sym_d        = CNT_W'(1);
        slot_d       = '0;
        hdr_d        = 1'b1;
        classified_c = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            // non-sof symbols outside a frame are dropped
          end
          HEADER: begin
            hdr_d        = 1'b1;
            classified_c = 1'b1;
            if (sym_q == CNT_W'(HDR_LEN - 1)) begin
              sym_d   = '0;
              slot_d  = '0;
              // A zero-slot frame is header only.
              state_d = (slots_q == '0) ? IDLE : DATA;
            end else begin
              sym_d = sym_q + CNT_W'(1);
            end
          end
          DATA: begin
            xfec_d       = 1'b1;
            classified_c = 1'b1;
            if (sym_q == CNT_W'(SLOT_LEN - 1)) begin
              sym_d = '0;
              if (last_slot_c) begin
                done_d  = 1'b1;
                slot_d  = '0;
                state_d = IDLE;
              end else begin
                slot_d = slot_q + SLOT_W'(1);
                if (pilot_due_c) begin
                  state_d = PILOT;
                end
              end
            end else begin
              sym_d = sym_q + CNT_W'(1);
            end
          end
          PILOT: begin
            pil_d        = 1'b1;
            classified_c = 1'b1;
            if (sym_q == CNT_W'(PILOT_LEN - 1)) begin
              // slot_q already points at the slot after the pilot block
              sym_d   = '0;
              state_d = DATA;
            end else begin
              sym_d = sym_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    // I/Q follows the input only for symbols that carry a class flag.
    re_d = classified_c ? bus.sym_re_in : re_q;
    im_d = classified_c ? bus.sym_im_in : im_q;
  end

  assign bus.pl_header_vld  = hdr_q;
  assign bus.pl_pilot_vld   = pil_q;
  assign bus.xfec_frame_vld = xfec_q;
  assign bus.symbol_re_out  = re_q;
  assign bus.symbol_im_out  = im_q;
  assign bus.frame_done     = done_q;
  assign bus.sof_err        = sof_e_q;
  assign bus.cfg_err        = cfg_e_q;

endmodule

// File: tb/tb_pl_deframer.sv
// tb_pl_deframer: randomized stimulus against a queue-based frame model.
// Each sof builds the full expected class sequence of the frame from the
// frame-layout rules; each later symbol event pops one entry.
module tb_pl_deframer;

  logic sys_clk;
  logic rst_n;

  pl_deframer_if bus ();

  pl_deframer dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // model state
  byte unsigned q[$];       // 1=header 2=pilot 3=data
  bit           q_done;
  logic [5:0]   prev_f;     // {hdr, pil, xfec, done, sof_err, cfg_err}
  logic [15:0]  prev_r;
  logic [15:0]  prev_i;

  // observed statistics for the current run
  int h_n, p_n, x_n, fd_n, se_n, ce_n, fd_at, se_at, first_p_at, out_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    h_n = 0; p_n = 0; x_n = 0; fd_n = 0; se_n = 0; ce_n = 0;
    fd_at = -1; se_at = -1; first_p_at = -1; out_idx = 0;
  endtask

  // Expected class sequence of a whole frame.
  task automatic build(input int ns, input bit pe);
    q.delete();
    repeat (90) q.push_back(8'd1);
    for (int s = 0; s < ns; s++) begin
      repeat (90) q.push_back(8'd3);
      if (pe && ((s + 1) % 16 == 0) && (s != ns - 1))
        repeat (36) q.push_back(8'd2);
    end
    q_done = (ns != 0);
  endtask

  // One clock: drive, advance the model, compare.
  task automatic cyc(input bit fs, input bit vld, input bit sf,
                     input logic [15:0] re, input logic [15:0] im,
                     input int ns, input bit pe, input bit rst);
    logic [5:0]  ef, of;
    logic [15:0] er, ei;
    byte unsigned c;
    @(negedge sys_clk);
    rst_n          = rst;
    bus.fs_en      = fs;
    bus.sym_vld    = vld;
    bus.sof        = sf;
    bus.sym_re_in  = re;
    bus.sym_im_in  = im;
    bus.xfec_slots = 9'(ns);
    bus.pilot_en   = pe;
    @(posedge sys_clk);
    #1;
    if (!rst) begin
      ef = '0; er = '0; ei = '0;
      q.delete();
    end else if (!fs) begin
      ef = prev_f; er = prev_r; ei = prev_i;
    end else begin
      ef = '0; er = prev_r; ei = prev_i;
      if (vld) begin
        if (sf) begin
          ef[1] = (q.size() != 0);
          build(ns, pe);
          ef[0] = (ns == 0);
        end
        if (q.size() != 0) begin
          c = q.pop_front();
          ef[5] = (c == 8'd1);
          ef[4] = (c == 8'd2);
          ef[3] = (c == 8'd3);
          ef[2] = (q.size() == 0) && q_done;
          er = re; ei = im;
        end
      end
    end
    of = {bus.pl_header_vld, bus.pl_pilot_vld, bus.xfec_frame_vld,
          bus.frame_done, bus.sof_err, bus.cfg_err};
    chk("flags", 32'(of), 32'(ef));
    chk("re", 32'(bus.symbol_re_out), 32'(er));
    chk("im", 32'(bus.symbol_im_out), 32'(ei));
    prev_f = ef; prev_r = er; prev_i = ei;
    if (rst && fs) begin
      if (of[1]) begin se_n++; se_at = out_idx; end
      if (of[0]) ce_n++;
      if (of[5] | of[4] | of[3]) begin
        if (of[5]) h_n++;
        if (of[4]) begin
          p_n++;
          if (first_p_at < 0) first_p_at = out_idx;
        end
        if (of[3]) x_n++;
        if (of[2]) begin fd_n++; fd_at = out_idx; end
        out_idx++;
      end
    end
  endtask

  // Sof symbol then non-sof events until the model frame ends or `limit`
  // symbol events have been sent. I/Q carries the symbol index.
  task automatic run_frame(input int ns, input bit pe, input bit gaps, input int limit);
    int  idx;
    int  guard;
    bit  fs, vld;
    idx = 0;
    guard = 0;
    cyc(1'b1, 1'b1, 1'b1, 16'(idx), 16'(idx * 3 + 7), ns, pe, 1'b1);
    idx++;
    while (q.size() != 0 && (limit < 0 || idx < limit)) begin
      fs  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc(fs, vld, 1'b0, 16'(idx), 16'(idx * 3 + 7),
          int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'b1);
      if (fs && vld) idx++;
      guard++;
      if (guard > 20000) begin
        chk("run_bound", 32'(guard), 32'(0));
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fs_en = 1'b0; bus.sym_vld = 1'b0; bus.sof = 1'b0;
    bus.sym_re_in = '0; bus.sym_im_in = '0; bus.xfec_slots = '0; bus.pilot_en = 1'b0;
    prev_f = '0; prev_r = '0; prev_i = '0; q_done = 1'b0;
    clr_stats();

    // reset, then stray non-sof symbols in IDLE
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678, 4, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 4, 1'b0, 1'b1);

    // 4 slots, no pilots, continuous
    clr_stats();
    run_frame(4, 1'b0, 1'b0, -1);
    chk("s4_hdr", 32'(h_n), 32'(90));
    chk("s4_data", 32'(x_n), 32'(360));
    chk("s4_pilot", 32'(p_n), 32'(0));
    chk("s4_done_at", 32'(fd_at), 32'(449));

    // 33 slots with pilots
    clr_stats();
    run_frame(33, 1'b1, 1'b0, -1);
    chk("s33_pilot", 32'(p_n), 32'(72));
    chk("s33_data", 32'(x_n), 32'(2970));
    chk("s33_done_at", 32'(fd_at), 32'(3131));

    // 16 then 17 slots back-to-back
    clr_stats();
    run_frame(16, 1'b1, 1'b0, -1);
    chk("s16_pilot", 32'(p_n), 32'(0));
    chk("s16_done", 32'(fd_n), 32'(1));
    clr_stats();
    run_frame(17, 1'b1, 1'b0, -1);
    chk("s17_pilot", 32'(p_n), 32'(36));
    chk("s17_pilot_at", 32'(first_p_at), 32'(1530));
    chk("s17_done_at", 32'(fd_at), 32'(1655));

    // sof at DATA slot 2 symbol 10 (frame index 280), then a 1-slot frame
    clr_stats();
    run_frame(5, 1'b0, 1'b0, 280);
    run_frame(1, 1'b0, 1'b0, -1);
    chk("abort_sof_err", 32'(se_n), 32'(1));
    chk("abort_sof_at", 32'(se_at), 32'(280));
    chk("abort_done_n", 32'(fd_n), 32'(1));
    chk("abort_hdr", 32'(h_n), 32'(180));

    // fs_en / sym_vld gaps
    clr_stats();
    run_frame(4, 1'b0, 1'b1, -1);
    chk("gap_hdr", 32'(h_n), 32'(90));
    chk("gap_data", 32'(x_n), 32'(360));
    chk("gap_done_at", 32'(fd_at), 32'(449));

    // reset mid-pilot, ignored symbols, zero-slot frame
    run_frame(17, 1'b1, 1'b0, 1540);
    cyc(1'b1, 1'b1, 1'b0, 16'hbeef, 16'hcafe, 17, 1'b1, 1'b0);
    clr_stats();
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 17, 1'b1, 1'b1);
    chk("post_rst_idle", 32'(out_idx), 32'(0));
    run_frame(0, 1'b1, 1'b0, -1);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 3, 1'b0, 1'b1);
    chk("cfg_err_n", 32'(ce_n), 32'(1));
    chk("cfg_hdr", 32'(h_n), 32'(90));
    chk("cfg_done_n", 32'(fd_n), 32'(0));
    chk("cfg_total", 32'(out_idx), 32'(90));

    // random frames with gaps
    for (int k = 0; k < 3; k++)
      run_frame(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1'b1, -1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
